// File: rtl/mult_div_unit_pkg.sv
// Shared opcode constants and FSM state encoding for the HI/LO multiply/divide unit.
// The decoder in the controller imports the same definitions.
package mult_div_unit_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_OP_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 3'd6;
  localparam logic [MD_OP_W-1:0] MD_OP_RSVD  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_compute.sv
// Combinational 64-bit HI/LO result for MULT/MULTU/DIV/DIVU on latched operands.
// keep=1 tells the owner of HI/LO to leave them untouched (divide by zero, non-arith ops).
module md_compute
  import mult_div_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [31:0]        hi_n,
  output logic [31:0]        lo_n,
  output logic               keep
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [63:0] a_x;
  logic signed [63:0] b_x;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign a_s    = a;
  assign b_s    = b;
  assign a_x    = 64'(a_s);
  assign b_x    = 64'(b_s);
  assign prod_s = a_x * b_x;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow.
  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign signed_div = (op == MD_OP_DIV);
  assign a_mag      = (signed_div && a[31]) ? (32'd0 - a) : a;
  assign b_mag      = (signed_div && b[31]) ? (32'd0 - b) : b;
  assign div_b      = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / div_b;
  assign r_mag      = a_mag % div_b;
  assign quot       = (signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem        = (signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    hi_n = 32'd0;
    lo_n = 32'd0;
    keep = 1'b1;
    case (op)
      MD_OP_MULT: begin
        {hi_n, lo_n} = prod_s;
        keep         = 1'b0;
      end
      MD_OP_MULTU: begin
        {hi_n, lo_n} = prod_u;
        keep         = 1'b0;
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        lo_n = quot;
        hi_n = rem;
        keep = (b == 32'd0);
      end
      default: begin
        keep = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage; owns HI/LO and reports busy.
// Optional feature macro: MDU_FLUSH_EN adds a flush port that cancels any in-flight op.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
`ifdef MDU_FLUSH_EN
  input  logic               flush,
`endif
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  logic flush_i;
`ifdef MDU_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  md_state_e          state_q;
  md_state_e          state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               load;
  logic               commit;
  logic               wr_hi;
  logic               wr_lo;

  logic [MD_OP_W-1:0] op_p0;
  logic [31:0]        a_p0;
  logic [31:0]        b_p0;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_keep;

  // Next-state: flush overrides everything, including MTHI/MTLO and a new start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_long_op(md_op)) begin
              load    = 1'b1;
              cnt_d   = is_div_op(md_op) ? DIV_LAST : MULT_LAST;
              state_d = ST_RUN;
            end else if (md_op == MD_OP_MTHI) begin
              wr_hi = 1'b1;
            end else if (md_op == MD_OP_MTLO) begin
              wr_lo = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p0: operands captured on the accepting edge; inputs are free to change after.
  always_ff @(posedge clk) begin
    if (load) begin
      op_p0 <= md_op;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  md_compute u_compute (
    .op   (op_p0),
    .a    (a_p0),
    .b    (b_p0),
    .hi_n (res_hi),
    .lo_n (res_lo),
    .keep (res_keep)
  );

  // HI/LO are architectural state, so they clear on reset like the control path.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit) begin
      if (!res_keep) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else begin
      if (wr_hi) hi_q <= a;
      if (wr_lo) lo_q <= a;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected HI/LO and busy length,
// a monitor pops and compares whenever busy falls.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
`ifdef MDU_FLUSH_EN
    .flush (flush),
`endif
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: architectural MIPS HI/LO semantics in plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] eh, inout logic [31:0] el);
    longint      sx, sy, q, r;
    logic [63:0] p;
    case (op)
      MD_OP_MULT: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        eh = p[63:32];
        el = p[31:0];
      end
      MD_OP_MULTU: begin
        p  = {32'd0, x} * {32'd0, y};
        eh = p[63:32];
        el = p[31:0];
      end
      MD_OP_DIV: if (y != 32'd0) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        el = q[31:0];
        eh = r[31:0];
      end
      MD_OP_DIVU: if (y != 32'd0) begin
        el = x / y;
        eh = x % y;
      end
      MD_OP_MTHI: eh = x;
      MD_OP_MTLO: el = x;
      default: ;
    endcase
  endfunction

  // Monitor: sampled 2 time units after the rising edge.
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;
  always @(posedge clk) begin
    #2;
    if (reset || flush) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: busy fell after %0d cycles with nothing expected", busy_cnt);
        end else begin
          cur = sb.pop_front();
          check("done_hi", hi, cur.hi);
          check("done_lo", lo, cur.lo);
          check("busy_len", 32'(busy_cnt), 32'(cur.len));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Called at a negedge while the unit is idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit track);
    logic [31:0] eh, el;
    eh = hi_m;
    el = lo_m;
    start = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    if (track) begin
      model(op, x, y, eh, el);
      if (is_long_op(op)) sb.push_back('{hi: eh, lo: el, len: (is_div_op(op) ? DIV_N : MULT_N)});
      hi_m = eh;
      lo_m = el;
    end
    @(negedge clk);
    start = 1'b0;
    md_op = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) @(negedge clk);
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b required 0 within 64 cycles", busy);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] x, y;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MULT discards it.
    issue(MD_OP_MULT, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstrun_busy", {31'd0, busy}, 32'd0);
    check("rstrun_hi", hi, 32'd0);
    check("rstrun_lo", lo, 32'd0);

    issue(MD_OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle();
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle();
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(MD_OP_DIVU, 32'd7, 32'd2, 1'b1);
    wait_idle();
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    issue(MD_OP_MTHI, 32'h1234, 32'd0, 1'b1);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // MTLO and MULT presented while busy must be ignored.
    issue(MD_OP_MULT, 32'd1000, 32'd3000, 1'b1);
    start = 1'b1;
    md_op = MD_OP_MTLO;
    a     = 32'hDEAD_BEEF;
    @(negedge clk);
    md_op = MD_OP_MULT;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd3_000_000);

    // Divide by zero keeps HI/LO, then an immediate MULT on the first idle cycle.
    issue(MD_OP_MTHI, 32'd5, 32'd0, 1'b1);
    issue(MD_OP_MTLO, 32'd6, 32'd0, 1'b1);
    issue(MD_OP_DIVU, 32'd99, 32'd0, 1'b1);
    wait_idle();
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'd6);
    issue(MD_OP_MULT, 32'd6, 32'd7, 1'b1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check("b2b_lo", lo, 32'd42);

`ifdef MDU_FLUSH_EN
    issue(MD_OP_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, hi_m);
    check("flush_lo", lo, lo_m);
    flush = 1'b1;
    start = 1'b1;
    md_op = MD_OP_MTLO;
    a     = 32'h0BAD_0BAD;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_mtlo_lo", lo, lo_m);
    check("flush_mtlo_busy", {31'd0, busy}, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = rnd_val();
      y  = rnd_val();
      issue(op, x, y, 1'b1);
      if (is_long_op(op)) begin
        wait_idle();
      end else begin
        check("rnd_short_busy", {31'd0, busy}, 32'd0);
      end
      check("rnd_hi", hi, hi_m);
      check("rnd_lo", lo, lo_m);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
